// File: rtl/main_memory_arbiter.sv
// rtl/main_memory_arbiter.sv - two-port round-robin arbiter and sequencer for the shared main memory
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (port 0 always wins on contention; default is round robin)
module main_memory_arbiter #(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH     = 32,
    parameter int ACC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [AWIDTH-1:0] p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DWIDTH-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [AWIDTH-1:0] p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DWIDTH-1:0] p1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Strobe hold counter preset; counts down to zero while in ACCESS.
    localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

    state_t            state_q,     state_d;
    logic [3:0]        count_q,     count_d;
    logic              gnt_q,       gnt_d;
    logic              mem_rd_q,    mem_rd_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [AWIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic              p0_ack_q,    p0_ack_d;
    logic              p1_ack_q,    p1_ack_d;
    logic [DWIDTH-1:0] p0_rdata_q,  p0_rdata_d;
    logic [DWIDTH-1:0] p1_rdata_q,  p1_rdata_d;
    logic              busy_q,      busy_d;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
    logic              last_gnt_q,  last_gnt_d;
`endif

    logic pick;

    // Arbitration: which port wins if a grant is issued this cycle (0 = port 0, 1 = port 1).
    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        pick = ~p0_req;
`else
        if (p0_req && p1_req) begin
            pick = ~last_gnt_q;
        end else begin
            pick = ~p0_req;
        end
`endif
    end

    // Next-state and next-output computation for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        gnt_d       = gnt_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
        last_gnt_d  = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                if (p0_req || p1_req) begin
                    gnt_d   = pick;
                    count_d = CNT_INIT;
                    state_d = ACCESS;
                    if (pick) begin
                        mem_addr_d  = p1_addr;
                        mem_wdata_d = p1_wdata;
                        mem_rd_d    = ~p1_we;
                        mem_wr_d    = p1_we;
                    end else begin
                        mem_addr_d  = p0_addr;
                        mem_wdata_d = p0_wdata;
                        mem_rd_d    = ~p0_we;
                        mem_wr_d    = p0_we;
                    end
                end
            end
            ACCESS: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    // Read data was launched on the preceding negedge and is valid now.
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (mem_rd_q) begin
                        if (gnt_q) begin
                            p1_rdata_d = mem_rdata;
                        end else begin
                            p0_rdata_d = mem_rdata;
                        end
                    end
                    if (gnt_q) begin
                        p1_ack_d = 1'b1;
                    end else begin
                        p0_ack_d = 1'b1;
                    end
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
                    last_gnt_d = gnt_q;
`endif
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any access in flight without an ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            gnt_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            last_gnt_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            gnt_q       <= gnt_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            last_gnt_q  <= last_gnt_d;
`endif
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// tb/tb_main_memory_arbiter.sv - directed-vector bench for main_memory_arbiter
module tb_main_memory_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        p0_req, p0_we, p1_req, p1_we;
    logic [8:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_rd, mem_wr, busy;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic        b_p0_req, b_p0_we, b_p1_req, b_p1_we;
    logic [8:0]  b_p0_addr, b_p1_addr;
    logic [31:0] b_p0_wdata, b_p1_wdata;
    logic        b_p0_ack, b_p1_ack;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic        b_mem_rd, b_mem_wr, b_busy;
    logic [8:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [31:0] b_mem_rdata = '0;

    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:511];

    main_memory_arbiter #(.AWIDTH(9), .DWIDTH(32), .ACC_CYCLES(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    main_memory_arbiter #(.AWIDTH(9), .DWIDTH(32), .ACC_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory models sample the command on the negedge between arbiter edges.
    always @(negedge clk) begin
        if (mem_wr) mem_a[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem_a[mem_addr];
        if (b_mem_wr) mem_b[b_mem_addr] <= b_mem_wdata;
        if (b_mem_rd) b_mem_rdata <= mem_b[b_mem_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input bit port, input logic we, input logic [8:0] addr, input logic [31:0] wd,
                           output int lat, output int rd_cyc, output int wr_cyc, output int other_ack);
        lat = 0; rd_cyc = 0; wr_cyc = 0; other_ack = 0;
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
        end
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (mem_rd) rd_cyc++;
            if (mem_wr) wr_cyc++;
            if (port ? p0_ack : p1_ack) other_ack = 1;
            if (port ? p1_ack : p0_ack) begin
                lat = i;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick;
    endtask

    int lat, rdc, wrc, oth;
    int starts, a0, a1, brd, addr_ok;
    int order [6];
    int at [6];

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[9'h005] = 32'hDEADBEEF;
        mem_a[9'h010] = 32'hA0A0A0A0;
        mem_a[9'h020] = 32'hB0B0B0B0;
        mem_b[9'h033] = 32'hCAFEF00D;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        b_p0_req = 0; b_p0_we = 0; b_p0_addr = '0; b_p0_wdata = '0;
        b_p1_req = 0; b_p1_we = 0; b_p1_addr = '0; b_p1_wdata = '0;
        reset_n = 1'b0;
        tick;
        tick;

        // Reset values
        check("rst_p0_ack",   32'(p0_ack),   32'd0);
        check("rst_p1_ack",   32'(p1_ack),   32'd0);
        check("rst_mem_rd",   32'(mem_rd),   32'd0);
        check("rst_mem_wr",   32'(mem_wr),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_p0_rdata", p0_rdata,      32'd0);
        reset_n = 1'b1;
        tick;

        // Single p0 read, cycle by cycle
        p0_we = 1'b0; p0_addr = 9'h005; p0_req = 1'b1;
        tick;
        check("t1_c1_mem_rd",   32'(mem_rd),   32'd1);
        check("t1_c1_mem_addr", 32'(mem_addr), 32'h005);
        check("t1_c1_busy",     32'(busy),     32'd1);
        check("t1_c1_p0_ack",   32'(p0_ack),   32'd0);
        tick;
        check("t1_c2_p0_ack",   32'(p0_ack),   32'd1);
        check("t1_c2_p0_rdata", p0_rdata,      32'hDEADBEEF);
        check("t1_c2_mem_rd",   32'(mem_rd),   32'd0);
        check("t1_c2_p1_ack",   32'(p1_ack),   32'd0);
        p0_req = 1'b0;
        tick;
        check("t1_c3_busy",     32'(busy),     32'd0);
        check("t1_c3_p0_ack",   32'(p0_ack),   32'd0);
        check("t1_c3_p0_rdata", p0_rdata,      32'hDEADBEEF);

        // p1 write then read back
        run_one(1'b1, 1'b1, 9'h1FF, 32'h12345678, lat, rdc, wrc, oth);
        check("t2_wr_latency",  32'(lat), 32'd2);
        check("t2_wr_cycles",   32'(wrc), 32'd1);
        check("t2_wr_rd_cyc",   32'(rdc), 32'd0);
        check("t2_wr_p0_ack",   32'(oth), 32'd0);
        check("t2_mem_content", mem_a[9'h1FF], 32'h12345678);
        run_one(1'b1, 1'b0, 9'h1FF, 32'h0, lat, rdc, wrc, oth);
        check("t2_rd_latency",  32'(lat), 32'd2);
        check("t2_rd_cycles",   32'(rdc), 32'd1);
        check("t2_rd_wr_cyc",   32'(wrc), 32'd0);
        check("t2_rd_p0_ack",   32'(oth), 32'd0);
        check("t2_p1_rdata",    p1_rdata, 32'h12345678);
        check("t2_p0_rdata",    p0_rdata, 32'hDEADBEEF);

        // Contention: both ports request continuously
        p0_we = 1'b0; p0_addr = 9'h010;
        p1_we = 1'b0; p1_addr = 9'h020;
        p0_req = 1'b1; p1_req = 1'b1;
        starts = 0; a0 = 0; a1 = 0;
        for (int i = 0; i < 40 && starts < 6; i++) begin
            tick;
            if (p0_ack) a0++;
            if (p1_ack) a1++;
            if (mem_rd) begin
                order[starts] = (mem_addr == 9'h020) ? 1 : 0;
                at[starts] = i;
                starts++;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (p0_ack) a0++;
            if (p1_ack) a1++;
        end
        check("t3_starts", 32'(starts), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3_grant%0d", k), 32'(order[k]), FIXED ? 32'd0 : 32'(k % 2));
            if (k > 0) check($sformatf("t3_spacing%0d", k), 32'(at[k] - at[k-1]), 32'd3);
        end
        check("t3_p0_acks",  32'(a0),  FIXED ? 32'd6 : 32'd3);
        check("t3_p1_acks",  32'(a1),  FIXED ? 32'd0 : 32'd3);
        check("t3_p0_rdata", p0_rdata, 32'hA0A0A0A0);
        check("t3_p1_rdata", p1_rdata, FIXED ? 32'h12345678 : 32'hB0B0B0B0);

        // ACC_CYCLES=3 instance: single p0 read
        b_p0_we = 1'b0; b_p0_addr = 9'h033; b_p0_req = 1'b1;
        brd = 0; addr_ok = 1; lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (b_mem_rd) begin
                brd++;
                if (b_mem_addr !== 9'h033) addr_ok = 0;
            end
            if (b_p0_ack) begin
                lat = i;
                break;
            end
        end
        b_p0_req = 1'b0;
        tick;
        check("t4_rd_cycles",  32'(brd),     32'd3);
        check("t4_addr_stable",32'(addr_ok), 32'd1);
        check("t4_latency",    32'(lat),     32'd4);
        check("t4_p0_rdata",   b_p0_rdata,   32'hCAFEF00D);
        check("t4_busy_after", 32'(b_busy),  32'd0);

        // Reset in the middle of a p1 read
        run_one(1'b0, 1'b0, 9'h005, 32'h0, lat, rdc, wrc, oth);
        check("t5_pre_latency", 32'(lat), 32'd2);
        p1_we = 1'b0; p1_addr = 9'h1FF; p1_req = 1'b1;
        tick;
        check("t5_access_started", 32'(mem_rd), 32'd1);
        reset_n = 1'b0;
        tick;
        check("t5_rst_mem_rd", 32'(mem_rd), 32'd0);
        check("t5_rst_busy",   32'(busy),   32'd0);
        check("t5_rst_p1_ack", 32'(p1_ack), 32'd0);
        p1_req = 1'b0;
        tick;
        check("t5_rst2_p1_ack",   32'(p1_ack), 32'd0);
        check("t5_rst2_p1_rdata", p1_rdata,    32'd0);
        reset_n = 1'b1;
        p0_we = 1'b0; p0_addr = 9'h010; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 9'h020; p1_req = 1'b1;
        tick;
        check("t5_first_rd",   32'(mem_rd),   32'd1);
        check("t5_first_addr", 32'(mem_addr), 32'h010);
        p0_req = 1'b0; p1_req = 1'b0;
        a0 = 0; a1 = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (p0_ack) a0++;
            if (p1_ack) a1++;
        end
        check("t5_p0_acks", 32'(a0), 32'd1);
        check("t5_p1_acks", 32'(a1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
